register_file_sb: RTL
=====================

Name: register_file_sb

Overview:
- Parametrised successor to the single-port register bank.
- Provides one synchronous write port, two combinational read ports, a hard-wired zero register option and a per-register busy scoreboard for in-flight producers.
- Sits between decode (read, alloc) and writeback (write) in the pipeline; decode uses the busy flags to stall on RAW hazards.

Parameters:
DATA_WIDTH, 16, bits per register
ADDRESS_WIDTH, 3, register index width; depth = 2**ADDRESS_WIDTH
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and allocs; 0 = register 0 is ordinary

Ports:
clk  input  1  single clock, all state updates on rising edge
reset  input  1  asynchronous, active-low; 0 clears all state immediately
write  input  1  writeback strobe
addr_in  input  ADDRESS_WIDTH  write index
data_in  input  DATA_WIDTH  write data
addr_a  input  ADDRESS_WIDTH  read port A index
addr_b  input  ADDRESS_WIDTH  read port B index
data_a  output  DATA_WIDTH  read port A data
data_b  output  DATA_WIDTH  read port B data
alloc  input  1  decode claims a destination register
alloc_addr  input  ADDRESS_WIDTH  claimed register index
busy_a  output  1  register addr_a has an outstanding producer
busy_b  output  1  register addr_b has an outstanding producer
waw  output  1  alloc to an already-busy register this cycle

Behaviour:
- Reset (reset=0, asynchronous): all registers = 0 and all busy bits = 0, effective immediately without a clock edge.
  - While reset is low, data_a/b = 0, busy_a/b = 0, waw = 0.
  - Clock edges during reset have no effect.
  - Deassertion takes effect on the next rising edge.
- Write:
  - At the rising edge with write=1, bank[addr_in] <= data_in.
  - Suppressed when ZERO_REG=1 and addr_in=0.
  - Data is visible on the read ports in the following cycle (1-cycle write latency without bypass).
- Read:
  - data_a = bank[addr_a] and data_b = bank[addr_b], combinational, 0 cycles.
  - ZERO_REG=1 and addr=0 forces 0.
  - Both ports may use the same index.
- Scoreboard, one busy bit per register:
  - At the rising edge, write=1 clears busy[addr_in].
  - At the rising edge, alloc=1 sets busy[alloc_addr].
  - Same edge, same index for write and alloc: alloc wins and busy stays 1 (a new producer supersedes).
  - Same edge, different indices: both updates apply.
  - alloc or write to register 0 with ZERO_REG=1 leaves busy[0] = 0 permanently.
  - A write to a non-busy register is legal: the data is written and busy stays 0.
- busy_a = busy[addr_a]; busy_b = busy[addr_b] (combinational).
- waw = alloc & busy[alloc_addr], combinational.
  - Informational only; the alloc still takes effect.
  - Forced 0 for register 0 when ZERO_REG=1.
- Index width: all indices are exactly ADDRESS_WIDTH bits, so there is no out-of-range case.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If write=1 and addr_in == addr_a (and not a suppressed register 0), then data_a = data_in and busy_a = 0 in the same cycle.
  - If a same-cycle alloc targets that index, busy_a = 1.
  - Port B behaves identically.
- Undefined: no forwarding.
  - data_a/b show the old value until the next cycle.
  - busy_a/b reflect the stored bit only.

Test Plan:
- Reset clears state: write 0xBEEF to reg 5, pulse reset low mid-cycle (no clock edge) -> data_a (addr_a=5) = 0x0000 and busy_a = 0 immediately.
- Zero register: ZERO_REG=1, write 0x1234 to reg 0, alloc reg 0 -> data_a(0) = 0x0000, busy_a = 0, waw = 0; with ZERO_REG=0 -> data_a(0) = 0x1234 next cycle.
- Dual read: write 0x00AA to r3 and 0x0055 to r6 on consecutive edges; addr_a=3, addr_b=6 -> data_a = 0x00AA, data_b = 0x0055; addr_a=addr_b=3 -> both 0x00AA.
- Scoreboard lifecycle: alloc r2 -> busy_a(2) = 1 next cycle; alloc r2 again -> waw = 1; write r2 = 0x0F0F -> busy = 0 and data = 0x0F0F next cycle.
- Collision: same edge write r4 and alloc r4 -> busy[4] = 1 and bank[4] updated; same edge write r4 and alloc r1 -> busy[4] = 0, busy[1] = 1.
- Bypass: addr_a=7, write r7 = 0xCAFE -> with REGFILE_BYPASS_EN, data_a = 0xCAFE and busy_a = 0 in the same cycle; without it, data_a = old value until the next edge.

Source files
------------

// File: rtl/register_file_sb.sv
// register_file_sb: 1W/2R register file with optional hard-wired zero register and busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module register_file_sb #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 3,
    parameter int ZERO_REG      = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     write,
    input  logic [ADDRESS_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic [ADDRESS_WIDTH-1:0] addr_a,
    input  logic [ADDRESS_WIDTH-1:0] addr_b,
    output logic [DATA_WIDTH-1:0]    data_a,
    output logic [DATA_WIDTH-1:0]    data_b,
    input  logic                     alloc,
    input  logic [ADDRESS_WIDTH-1:0] alloc_addr,
    output logic                     busy_a,
    output logic                     busy_b,
    output logic                     waw
);
    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DATA_WIDTH-1:0] bank_q [DEPTH];
    logic [DATA_WIDTH-1:0] bank_d [DEPTH];
    logic [DEPTH-1:0]      busy_q, busy_d;
    logic                  wr_en, al_en, fwd_a, fwd_b;

    function automatic logic is_zero(input logic [ADDRESS_WIDTH-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign wr_en = write && !is_zero(addr_in);
    assign al_en = alloc && !is_zero(alloc_addr);
    assign fwd_a = BYPASS && wr_en && (addr_in == addr_a);
    assign fwd_b = BYPASS && wr_en && (addr_in == addr_b);

    // alloc is applied after the write so a same-index collision leaves the register busy
    always_comb begin
        bank_d = bank_q;
        busy_d = busy_q;
        if (wr_en) begin
            bank_d[addr_in] = data_in;
            busy_d[addr_in] = 1'b0;
        end
        if (al_en) busy_d[alloc_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
            for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
        end else begin
            busy_q <= busy_d;
            bank_q <= bank_d;
        end
    end

    assign data_a = (!reset || is_zero(addr_a)) ? '0 : fwd_a ? data_in : bank_q[addr_a];
    assign data_b = (!reset || is_zero(addr_b)) ? '0 : fwd_b ? data_in : bank_q[addr_b];
    assign busy_a = reset && (fwd_a ? (al_en && alloc_addr == addr_a) : busy_q[addr_a]);
    assign busy_b = reset && (fwd_b ? (al_en && alloc_addr == addr_b) : busy_q[addr_b]);
    assign waw    = reset && al_en && busy_q[alloc_addr];
endmodule
